// File: rtl/gf2m59_reduce_seq.sv
// gf2m59_reduce_seq: sequential reducer for 117-bit GF(2) products into
// GF(2^59) elements, modulo x^59 + POLY_LOW. Each FOLD cycle clears up to
// STEP of the high-order bits [116:59], working downward from bit 116.
// The result is presented under a valid/ready handshake.
// Optional feature: define GF59_RED_OPCNT_EN to add the op_count port.
// op_count counts completed output handshakes.
module gf2m59_reduce_seq #(
  parameter logic [58:0] POLY_LOW = 59'h95,
  parameter int          STEP     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [116:0]  in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [58:0]   out_c,
  output logic          busy
`ifdef GF59_RED_OPCNT_EN
  ,
  output logic [15:0]   op_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0]   POS_TOP  = 7'd116;
  localparam logic [6:0]   POS_LSB  = 7'd59;
  localparam logic [6:0]   STEP_W   = 7'(STEP);
  // The full modulus x^59 + POLY_LOW, aligned at bit 0. It is shifted up to
  // cancel a set coefficient at position k >= 59.
  localparam logic [116:0] POLY_EXT = {57'd0, 1'b1, POLY_LOW};

  state_t         state_q, state_d;
  logic [116:0]   acc_q, acc_d;
  logic [6:0]     pos_q, pos_d;

  // One FOLD cycle's worth of reduction. Bits are folded from p downward,
  // in order. A fold at bit k can set lower bits inside the same window, and
  // later steps of the chain must see those updated bits.
  function automatic logic [116:0] fold_window(input logic [116:0] a,
                                               input logic [6:0]   p);
    logic [116:0] r;
    logic [6:0]   k;
    r = a;
    for (int j = 0; j < STEP; j++) begin
      k = p - 7'(j);
      if ((k >= POS_LSB) && r[k]) begin
        r = r ^ (POLY_EXT << (k - POS_LSB));
      end
    end
    return r;
  endfunction

  // State, accumulator and bit-position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      pos_q   <= POS_TOP;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
    end
  end

  // Next-state logic, the fold datapath and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pos_d     = pos_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_c     = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_d;
          pos_d   = POS_TOP;
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        busy  = 1'b1;
        acc_d = fold_window(acc_q, pos_q);
        // pos >= 59 and STEP <= 58 here, so this subtraction cannot wrap.
        pos_d = pos_q - STEP_W;
        if (pos_d < POS_LSB) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_c     = acc_q[58:0];
        // An in_valid in this cycle is not looked at; it is taken in IDLE.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef GF59_RED_OPCNT_EN
  logic [15:0] op_count_q;

  // Counts completed output handshakes. The count wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if ((state_q == S_DONE) && out_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_gf2m59_reduce_seq.sv
// tb_gf2m59_reduce_seq: directed and random checks of gf2m59_reduce_seq.
// Build with GF59_RED_OPCNT_EN defined to also check op_count.
module tb_gf2m59_reduce_seq;

  localparam logic [58:0] POLY = 59'h95;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [116:0]  in_d;
  logic          out_valid;
  logic          out_ready;
  logic [58:0]   out_c;
  logic          busy;
`ifdef GF59_RED_OPCNT_EN
  logic [15:0]   op_count;
`endif

  int            n_chk;
  int            n_fail;
  int            lat;
  bit            busy_low;
  logic [116:0]  d;
  logic [58:0]   e;
  logic [58:0]   held;
  int            stall;

  gf2m59_reduce_seq #(.POLY_LOW(POLY), .STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy)
`ifdef GF59_RED_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  // Horner evaluation of d(x) mod (x^59 + POLY): res = res*x + d_i from the
  // top coefficient down, reducing x^59 whenever it appears.
  function automatic logic [58:0] gf_ref(input logic [116:0] dv);
    logic [58:0]  res;
    logic [116:0] s;
    logic         carry;
    res = '0;
    s   = dv;
    for (int i = 0; i < 117; i++) begin
      carry = res[58];
      res   = {res[57:0], s[116]};
      if (carry) res = res ^ POLY;
      s = s << 1;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [116:0] obs, input logic [116:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [116:0] dv);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_d     = dv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_d     = 117'({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  // Counts rising edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_valid(input bit rnd_ready, output int l, output bit bl);
    l  = 1;
    bl = 1'b0;
    while (out_valid !== 1'b1 && l < 40) begin
      if (busy !== 1'b1) bl = 1'b1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst in_ready", 117'(in_ready), 117'(1'b1));
    chk("rst out_valid", 117'(out_valid), 117'(1'b0));
    chk("rst out_c", 117'(out_c), 117'(0));
    chk("rst busy", 117'(busy), 117'(1'b0));
`ifdef GF59_RED_OPCNT_EN
    chk("rst op_count", 117'(op_count), 117'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // T1: x^59 -> POLY_LOW, with out_ready held high through FOLD
    out_ready = 1'b1;
    start_op(117'd1 << 59);
    wait_valid(1'b0, lat, busy_low);
    chk("T1 latency", 117'(lat), 117'(9));
    chk("T1 out_c", 117'(out_c), 117'(59'h95));
    chk("T1 in_ready DONE", 117'(in_ready), 117'(1'b0));
    chk("T1 busy DONE", 117'(busy), 117'(1'b1));
    handshake();
    chk("T1 in_ready after", 117'(in_ready), 117'(1'b1));
    chk("T1 out_valid after", 117'(out_valid), 117'(1'b0));
    chk("T1 out_c after", 117'(out_c), 117'(0));
    chk("T1 busy after", 117'(busy), 117'(1'b0));
`ifdef GF59_RED_OPCNT_EN
    chk("T1 op_count", 117'(op_count), 117'(1));
`endif

    // T2: no high bits, still N fold cycles, busy throughout
    start_op(117'h5A);
    wait_valid(1'b0, lat, busy_low);
    chk("T2 latency", 117'(lat), 117'(9));
    chk("T2 busy low seen", 117'(busy_low), 117'(1'b0));
    chk("T2 out_c", 117'(out_c), 117'(59'h5A));
    handshake();

    // T3: x^116 -> x^57 + x^12 + x^6 + x^5 + 1
    start_op(117'd1 << 116);
    wait_valid(1'b0, lat, busy_low);
    chk("T3 out_c", 117'(out_c), 117'(59'h0200_0000_0000_1061));
    handshake();

    // x^60 -> x^8 + x^5 + x^3 + x
    start_op(117'd1 << 60);
    wait_valid(1'b0, lat, busy_low);
    chk("x60 out_c", 117'(out_c), 117'(59'h12A));
    handshake();

    // x^60 + x^59 + 0x5A -> 0x12A ^ 0x95 ^ 0x5A
    start_op((117'd1 << 60) | (117'd1 << 59) | 117'h5A);
    wait_valid(1'b0, lat, busy_low);
    chk("mix out_c", 117'(out_c), 117'(59'h1E5));
    handshake();

    // T4: 5-cycle stall in DONE, then in_valid alongside the DONE handshake
    start_op(117'd1 << 116);
    wait_valid(1'b0, lat, busy_low);
    for (int i = 0; i < 5; i++) begin
      chk("T4 stall out_c", 117'(out_c), 117'(59'h0200_0000_0000_1061));
      chk("T4 stall out_valid", 117'(out_valid), 117'(1'b1));
      chk("T4 stall in_ready", 117'(in_ready), 117'(1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b1;
    in_d      = 117'd1 << 59;
    out_ready = 1'b1;
    chk("T4 in_ready at hs", 117'(in_ready), 117'(1'b0));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("T4 in_ready next", 117'(in_ready), 117'(1'b1));
    chk("T4 busy next", 117'(busy), 117'(1'b0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("T4 accepted busy", 117'(busy), 117'(1'b1));
    chk("T4 accepted in_ready", 117'(in_ready), 117'(1'b0));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("T4 second latency", 117'(lat), 117'(8));
    chk("T4 second out_c", 117'(out_c), 117'(59'h95));
    handshake();

    // T5: reset during FOLD cycle 3, then during DONE
    start_op(117'd1 << 116);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("T5 busy before rst", 117'(busy), 117'(1'b1));
    rst = 1'b1;
    #1;
    chk("T5 rst in_ready", 117'(in_ready), 117'(1'b1));
    chk("T5 rst out_valid", 117'(out_valid), 117'(1'b0));
    chk("T5 rst busy", 117'(busy), 117'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("T5 idle after rst", 117'(busy), 117'(1'b0));
    start_op(117'd1 << 59);
    wait_valid(1'b0, lat, busy_low);
    chk("T5 latency", 117'(lat), 117'(9));
    chk("T5 out_c", 117'(out_c), 117'(59'h95));
    rst = 1'b1;
    #1;
    chk("T5 rst DONE out_valid", 117'(out_valid), 117'(1'b0));
    chk("T5 rst DONE out_c", 117'(out_c), 117'(0));
    chk("T5 rst DONE in_ready", 117'(in_ready), 117'(1'b1));
`ifdef GF59_RED_OPCNT_EN
    chk("T5 rst op_count", 117'(op_count), 117'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T6: random operands, random out_ready during FOLD and random DONE stalls
    for (int i = 0; i < 1000; i++) begin
      d = 117'({$urandom(), $urandom(), $urandom(), $urandom()});
      if (i % 8 == 0) d[116:59] = '0;
      e = gf_ref(d);
      start_op(d);
      wait_valid(1'b1, lat, busy_low);
      chk("T6 out_c", 117'(out_c), 117'(e));
      held  = out_c;
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        @(negedge clk);
        chk("T6 stall out_c", 117'(out_c), 117'(held));
      end
      handshake();
    end
`ifdef GF59_RED_OPCNT_EN
    chk("T6 op_count", 117'(op_count), 117'(1000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
